clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Programmable clock-divider controller that generates a divided square wave and a one-cycle period tick from the system clock. The divide ratio is configured through a valid/ready handshake. Ratio changes are applied only at a period boundary, so the output never produces a truncated or runt period. It replaces fixed divide-by-2/3 generators wherever a run-time selectable ratio is needed.

## Interface
- WIDTH, 4, width of ratio fields; legal ratios 0..2^WIDTH-1.
- clk  input  1  system clock; all state updates on rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- cfg_valid  input  1  requester presents a new ratio.
- cfg_ratio  input  WIDTH  requested divide ratio N; 0 means stop.
- cfg_ready  output  1  controller can accept a ratio this cycle.
- div_out  output  1  divided clock; high ceil(N/2) cycles, low floor(N/2) cycles.
- tick  output  1  one-cycle pulse on the first cycle of each output period.
- busy  output  1  a ratio change is pending.
- cur_ratio  output  WIDTH  ratio currently in effect; 0 when stopped.

## Operation
- Registers: state {STOP, RUN, PEND}, cnt[WIDTH], ratio_q[WIDTH], pend_q[WIDTH].
- A transfer occurs at a rising edge where cfg_valid && cfg_ready.
- cfg_ready = (state != PEND). busy = (state == PEND). cur_ratio = ratio_q.
- div_out and tick are flop outputs, loaded with the next-state decode; no combinational path from inputs.
  - tick = (state != STOP) && cnt == 0.
  - div_out = (state != STOP) && cnt < ((ratio_q+1)>>1). Compute the sum at WIDTH+1 bits so N=2^WIDTH-1 does not overflow.
- STOP:
  - Outputs are 0.
  - Transfer with N != 0: ratio_q <= N, cnt <= 0, go to RUN.
  - Transfer with N == 0: stay in STOP; no effect.
- RUN:
  - cnt increments each edge; it wraps to 0 on the edge where cnt == ratio_q-1.
  - Transfer: pend_q <= N, go to PEND. Counting continues unchanged. A transfer of N == ratio_q is still treated as a change.
- PEND:
  - Counting continues with the old ratio_q.
  - The first wrap edge strictly after the accepting edge is the switch edge: ratio_q <= pend_q, cnt <= 0.
  - At the switch edge, go to RUN if pend_q != 0, otherwise go to STOP with ratio_q = 0.
- N=1: cnt stays 0; tick = 1 and div_out = 1 every cycle while running. In PEND, the switch occurs on the next edge.
- cfg_ratio is ignored when no transfer occurs.

## Timing
- Reset (nrst low, asynchronous, immediate):
  - state=STOP; cnt, ratio_q, pend_q = 0.
  - div_out=0, tick=0, busy=0, cfg_ready=1, cur_ratio=0.
  - Any pending change is discarded.
- Start latency: after the accepting edge, the next cycle has tick=1, div_out=1, cnt=0. This is a 1-edge latency.
- Period is exactly N cycles; tick is high one cycle per period.
- Change latency: from the accepting edge to the switch edge is between 1 and ratio_q edges. The first new period begins the cycle after the switch edge, with tick=1.
- No period is shortened or lengthened at a ratio change.
- cfg_ready deasserts the cycle after the accepting edge in RUN, and reasserts the cycle after the switch edge.
- A new transfer can be accepted in the cycle right after the switch.
- Reset deassertion: the first edge with nrst high may accept a transfer.

## Test plan
- Reset, then transfer N=3 → tick 1,0,0 repeating; div_out 1,1,0 repeating; first tick one cycle after the accepting edge; cur_ratio=3.
- Running N=4, transfer N=2 on the cnt==1 edge → busy=1 and cfg_ready=0 for 2 cycles. Old 1,1,0,0 pattern completes, then 1,0 pattern. Tick spacing goes 4 then 2.
- Running N=5, transfer N=0 → current period (div_out 1,1,1,0,0) completes, then STOP: div_out=0, tick=0, cur_ratio=0, cfg_ready=1.
- N=1 running → tick=1 and div_out=1 every cycle. Transfer N=15 → switch on next edge. Then 8 high, 7 low, tick every 15 cycles; exercises the full-width ratio without overflow.
- In PEND, hold cfg_valid=1 with another ratio → no acceptance until cfg_ready returns; pend_q unchanged. While STOP, transfer N=0 → remains STOP.
- Assert nrst low mid-period while in PEND → all outputs go to reset values immediately, without waiting for an edge. After release, transfer N=2 → normal start.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a one-cycle period tick.
// New ratios take effect only at a period boundary, so no period is ever cut short.
module clk_div_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             div_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] cur_ratio
);

    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    state_t           state, n_state;
    logic [WIDTH-1:0] cnt, n_cnt;
    logic [WIDTH-1:0] ratio_q, n_ratio;
    logic [WIDTH-1:0] pend_q, n_pend;
    logic             xfer, wrap;
    logic [WIDTH:0]   half;

    assign cfg_ready = (state != PEND);
    assign busy      = (state == PEND);
    assign cur_ratio = ratio_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign wrap      = (cnt == ratio_q - WIDTH'(1));

    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_ratio = ratio_q;
        n_pend  = pend_q;
        case (state)
            STOP: begin
                if (xfer && cfg_ratio != '0) begin
                    n_state = RUN;
                    n_ratio = cfg_ratio;
                    n_cnt   = '0;
                end
            end
            RUN: begin
                n_cnt = wrap ? '0 : cnt + WIDTH'(1);
                if (xfer) begin
                    n_pend  = cfg_ratio;
                    n_state = PEND;
                end
            end
            PEND: begin
                // The old period always runs to its end before the switch.
                if (wrap) begin
                    n_cnt   = '0;
                    n_ratio = pend_q;
                    n_state = (pend_q != '0) ? RUN : STOP;
                end else begin
                    n_cnt = cnt + WIDTH'(1);
                end
            end
            default: n_state = STOP;
        endcase
    end

    // Sum at WIDTH+1 bits so the largest ratio does not wrap before the halving.
    assign half = ((WIDTH+1)'(n_ratio) + (WIDTH+1)'(1)) >> 1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= STOP;
            cnt     <= '0;
            ratio_q <= '0;
            pend_q  <= '0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            state   <= n_state;
            cnt     <= n_cnt;
            ratio_q <= n_ratio;
            pend_q  <= n_pend;
            tick    <= (n_state != STOP) && (n_cnt == '0);
            div_out <= (n_state != STOP) && ({1'b0, n_cnt} < half);
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected per-cycle outputs are queued as
// stimulus is planned and compared one entry per clock after each rising edge.
module tb_clk_div_ctrl;

    logic       clk;
    logic       nrst;
    logic       cfg_valid;
    logic [3:0] cfg_ratio;
    logic       cfg_ready;
    logic       div_out;
    logic       tick;
    logic       busy;
    logic [3:0] cur_ratio;

    typedef struct {
        bit tk;
        bit dv;
        bit bs;
        int cr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    clk_div_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy),
        .cur_ratio (cur_ratio)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input bit tk, input bit dv, input bit bs, input int cr);
        exp_t e;
        e.tk = tk;
        e.dv = dv;
        e.bs = bs;
        e.cr = cr;
        q.push_back(e);
    endtask

    // count cycles of a ratio-n waveform starting at phase 'from'
    task automatic push_cycles(input int n, input int from, input int count, input bit bs);
        int ph;
        ph = from;
        for (int i = 0; i < count; i++) begin
            push(ph == 0, ph < (n + 1) / 2, bs, n);
            ph = (ph + 1) % n;
        end
    endtask

    task automatic push_stop(input int count);
        for (int i = 0; i < count; i++) push(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_div"}, int'(div_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(cfg_ready), 1);
        chk({tag, "_ratio"}, int'(cur_ratio), 0);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("q_underrun", 1, 0);
        end else begin
            e = q.pop_front();
            chk("tick", int'(tick), int'(e.tk));
            chk("div_out", int'(div_out), int'(e.dv));
            chk("busy", int'(busy), int'(e.bs));
            chk("cfg_ready", int'(cfg_ready), int'(!e.bs));
            chk("cur_ratio", int'(cur_ratio), e.cr);
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic xfer(input int n);
        cfg_valid = 1'b1;
        cfg_ratio = 4'(n);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        nrst      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        nrst = 1'b1;

        // start at N=3
        push_cycles(3, 0, 9, 1'b0);
        xfer(3);
        steps(8);

        // 3 -> 4, accepted on a wrap edge; old period completes
        push_cycles(3, 0, 3, 1'b1);
        push_cycles(4, 0, 8, 1'b0);
        xfer(4);
        steps(10);

        // 4 -> 2, accepted on the cnt==1 edge
        push_cycles(4, 0, 2, 1'b0);
        steps(2);
        push_cycles(4, 2, 2, 1'b1);
        push_cycles(2, 0, 4, 1'b0);
        xfer(2);
        steps(5);

        // 2 -> 5, then 5 -> 0 late in the period
        push_cycles(2, 0, 2, 1'b1);
        push_cycles(5, 0, 4, 1'b0);
        xfer(5);
        steps(5);
        push_cycles(5, 4, 1, 1'b1);
        push_stop(3);
        xfer(0);
        steps(3);

        // N=0 while stopped has no effect
        push_stop(2);
        xfer(0);
        steps(1);

        // N=1, then switch to full-width 15 on the next edge
        push_cycles(1, 0, 4, 1'b0);
        xfer(1);
        steps(3);
        push_cycles(1, 0, 1, 1'b1);
        push_cycles(15, 0, 30, 1'b0);
        xfer(15);
        steps(30);

        // hold cfg_valid with another ratio through PEND; it must not replace 3
        push_cycles(15, 0, 15, 1'b1);
        push_cycles(3, 0, 1, 1'b0);
        cfg_valid = 1'b1;
        cfg_ratio = 4'd3;
        step();
        cfg_ratio = 4'd7;
        steps(15);
        cfg_valid = 1'b0;

        // accept immediately after the switch
        push_cycles(3, 1, 2, 1'b1);
        push_cycles(2, 0, 1, 1'b0);
        xfer(2);
        steps(2);

        // asynchronous reset while PEND
        push_cycles(2, 1, 1, 1'b1);
        xfer(4);
        #2;
        nrst = 1'b0;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        nrst = 1'b1;

        // restart after reset
        push_cycles(2, 0, 4, 1'b0);
        xfer(2);
        steps(3);

        chk("q_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
